mont_arbiter: RTL and testbench

Shares one Montgomery multiplier between two operand requesters: the squaring path (requester 0) and the multiply path (requester 1) of the modular-exponentiation controller. It accepts one request at a time with round-robin priority, latches the operands, and issues a single-cycle start to the multiplier. It waits for the multiplier's done, captures the product, and returns a one-cycle completion pulse to the granted requester. It sits between the RL exponentiation sequencer and the Montgomery datapath; modulus N bypasses it.

---
 rtl/rsa_pkg.sv | 36 +++
 rtl/mont_arbiter.sv | 108 ++++++++++
 tb/tb_mont_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation datapath:
// operand width ceiling, arbiter state encoding, requester ids and the
// two-way round-robin pick used by the multiplier arbiter.
package rsa_pkg;

    localparam int MAX_BIT = 2048;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Requester ids: squaring path and multiply path of the RL sequencer.
    localparam logic REQ_SQR = 1'b0;
    localparam logic REQ_MUL = 1'b1;

    // Two-input round-robin pick. On a tie the requester that did not win
    // last time goes first; a lone requester always wins. With nothing
    // valid the result is unused, so it falls back to REQ_SQR.
    function automatic logic rr_pick2(input logic valid0,
                                      input logic valid1,
                                      input logic last);
        logic pick;
        if (valid0 && valid1) begin
            pick = ~last;
        end else if (valid1) begin
            pick = REQ_MUL;
        end else begin
            pick = REQ_SQR;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mont_arbiter.sv
// Shares one Montgomery multiplier between the squaring requester (0) and
// the multiply requester (1). One operation is in flight at a time:
// grant in IDLE, one-cycle start/ack in ISSUE, wait for the multiplier in
// BUSY, one-cycle done pulse in RESP. Every output is a flop.
module mont_arbiter
    import rsa_pkg::*;
#(
    parameter int WIDTH = MAX_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    output logic             req0_ack,
    output logic             req1_ack,
    output logic             req0_done,
    output logic             req1_done,
    output logic [WIDTH-1:0] result,
    output logic             grant_id,
    output logic             busy,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_x,
    output logic [WIDTH-1:0] mm_y,
    input  logic             mm_done,
    input  logic [WIDTH-1:0] mm_o
);

    state_t state;
    logic   last_grant;
    logic   winner;

    // Winner is only consumed in IDLE when at least one request is valid.
    assign winner = rr_pick2(req0_valid, req1_valid, last_grant);

    // Arbitration FSM with registered handshakes, operand latches and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the wide operand and result registers are reset as well, because
            // mm_x, mm_y and result are visible outputs with a defined reset value.
            state      <= IDLE;
            last_grant <= REQ_MUL;
            grant_id   <= REQ_SQR;
            mm_x       <= '0;
            mm_y       <= '0;
            result     <= '0;
            mm_start   <= 1'b0;
            req0_ack   <= 1'b0;
            req1_ack   <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // NOTE: all state here is written with <= so every register samples
            // the pre-edge values; the pulse defaults below are overridden later
            // in the same block where a pulse is due.
            mm_start  <= 1'b0;
            req0_ack  <= 1'b0;
            req1_ack  <= 1'b0;
            req0_done <= 1'b0;
            req1_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        state      <= ISSUE;
                        grant_id   <= winner;
                        last_grant <= winner;
                        mm_x       <= (winner == REQ_MUL) ? req1_x : req0_x;
                        mm_y       <= (winner == REQ_MUL) ? req1_y : req0_y;
                        mm_start   <= 1'b1;
                        req0_ack   <= (winner == REQ_SQR);
                        req1_ack   <= (winner == REQ_MUL);
                        busy       <= 1'b1;
                    end
                end

                ISSUE: begin
                    state <= BUSY;
                end

                BUSY: begin
                    // The multiplier has no timeout; only its done ends the wait.
                    if (mm_done) begin
                        state     <= RESP;
                        result    <= mm_o;
                        req0_done <= (grant_id == REQ_SQR);
                        req1_done <= (grant_id == REQ_MUL);
                    end
                end

                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_arbiter.sv
// Self-checking bench for mont_arbiter at WIDTH=32. A fixed-latency
// multiplier model (mm_o = x + y, 10 cycles) answers mm_start. A
// transaction-level reference model predicts every output from grant and
// completion timestamps; a compare process checks it each cycle, and the
// directed scenarios add hand-computed literal expectations.
module tb_mont_arbiter;

    localparam int W      = 32;
    localparam int MM_LAT = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_x, req0_y, req1_x, req1_y;
    logic         req0_ack, req1_ack, req0_done, req1_done;
    logic [W-1:0] result;
    logic         grant_id, busy, mm_start;
    logic [W-1:0] mm_x, mm_y;
    logic         mm_done = 1'b0;
    logic [W-1:0] mm_o    = '0;
    logic         spur;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;

    always #5 clk = ~clk;

    mont_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req0_ack   (req0_ack),
        .req1_ack   (req1_ack),
        .req0_done  (req0_done),
        .req1_done  (req1_done),
        .result     (result),
        .grant_id   (grant_id),
        .busy       (busy),
        .mm_start   (mm_start),
        .mm_x       (mm_x),
        .mm_y       (mm_y),
        .mm_done    (mm_done),
        .mm_o       (mm_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- multiplier model (changes on the falling edge) ----------
    int           mm_cnt = 0;
    logic [W-1:0] mm_prod = '0;
    always @(negedge clk) begin : mult_model
        logic real_done;
        real_done = 1'b0;
        if (rst) begin
            mm_cnt = 0;
        end else if (mm_start) begin
            mm_cnt  = MM_LAT;
            mm_prod = mm_x + mm_y;
        end else if (mm_cnt > 0) begin
            mm_cnt--;
            real_done = (mm_cnt == 0);
        end
        mm_done = real_done | spur;
        mm_o    = real_done ? mm_prod : (spur ? 32'hDEAD_BEEF : '0);
    end

    // ---------------- transaction-level reference model -----------------------
    // An operation is described by the cycle it was granted in and the cycle
    // the multiplier answered in; every output follows from those two stamps.
    int           cyc = 0;
    bit           m_active = 1'b0;
    bit           m_done_seen = 1'b0;
    int           m_grant_cyc = 0;
    int           m_done_cyc = 0;
    logic         m_last = 1'b1;
    logic         m_gid = 1'b0;
    logic [W-1:0] m_x = '0, m_y = '0, m_res = '0;

    always @(posedge clk) begin : ref_model
        logic w;
        if (rst) begin
            m_active    = 1'b0;
            m_done_seen = 1'b0;
            m_last      = 1'b1;
            m_gid       = 1'b0;
            m_x         = '0;
            m_y         = '0;
            m_res       = '0;
        end else if (!m_active) begin
            if (req0_valid || req1_valid) begin
                w           = (req0_valid && req1_valid) ? !m_last : req1_valid;
                m_active    = 1'b1;
                m_done_seen = 1'b0;
                m_grant_cyc = cyc;
                m_gid       = w;
                m_last      = w;
                m_x         = w ? req1_x : req0_x;
                m_y         = w ? req1_y : req0_y;
            end
        end else if (!m_done_seen) begin
            // Cycle grant+1 is the start cycle; only later cycles listen for done.
            if (mm_done && cyc >= m_grant_cyc + 2) begin
                m_done_seen = 1'b1;
                m_done_cyc  = cyc;
                m_res       = mm_o;
            end
        end else if (cyc == m_done_cyc + 1) begin
            m_active = 1'b0;
        end
        cyc++;
    end

    // ---------------- per-cycle compare ---------------------------------------
    always @(negedge clk) begin : compare
        logic e_start, e_done;
        e_start = m_active && (cyc == m_grant_cyc + 1);
        e_done  = m_active && m_done_seen && (cyc == m_done_cyc + 1);
        if (mm_start) n_start++;
        check("ctrl", {req0_ack, req1_ack, req0_done, req1_done, mm_start, busy, grant_id},
              {e_start && !m_gid, e_start && m_gid, e_done && !m_gid, e_done && m_gid,
               e_start, m_active, m_gid});
        check("mm_x", mm_x, m_x);
        check("mm_y", mm_y, m_y);
        check("result", result, m_res);
    end

    // ---------------- stimulus helpers ----------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int id);
        case (id)
            0:       return req0_ack;
            1:       return req1_ack;
            2:       return req0_done;
            3:       return req1_done;
            4:       return !busy;
            default: return req0_ack || req1_ack;
        endcase
    endfunction

    // Advance at least one cycle until the selected signal is seen, bounded.
    task automatic wait_for(input string name, input int id, input int budget, output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (!sig(id) && k < budget);
        if (!sig(id)) check({name, "_timeout"}, sig(id), 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios -----------------------------------------------
    initial begin : stim
        int           k, s0, low, dones, w;
        logic [W-1:0] y0, y1, exp_sum, keep;
        logic [W-1:0] xc [2];
        logic [W-1:0] yc [2];
        bit           vr [2];

        rst = 1'b1; spur = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Idle after reset: nothing moves.
        s0 = n_start;
        repeat (20) tick();
        check("idle_no_start", n_start - s0, 0);
        check("idle_ctrl", {req0_ack, req1_ack, req0_done, req1_done, mm_start, busy, grant_id}, 0);
        check("idle_data", {mm_x, mm_y}, 0);
        check("idle_result", result, 0);

        // Single request from requester 0.
        req0_x = 5; req0_y = 7; req0_valid = 1'b1;
        wait_for("r0_ack", 0, 5, k);
        check("r0_ack_latency", k, 1);
        check("r0_start_with_ack", mm_start, 1);
        check("r0_mm_x", mm_x, 5);
        check("r0_mm_y", mm_y, 7);
        req0_valid = 1'b0;
        wait_for("r0_done", 2, 40, k);
        check("r0_done_latency", k, 11);
        check("r0_result", result, 12);
        check("r0_no_req1_done", req1_done, 0);
        wait_for("r0_idle", 4, 5, k);
        check("r0_busy_drop", k, 1);

        // Tie after reset: requester 0 first, then requester 1.
        pulse_reset();
        y0 = $urandom; y1 = $urandom;
        req0_x = 1; req0_y = y0; req1_x = 2; req1_y = y1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_for("tie_ack0", 5, 5, k);
        check("tie_first_is_0", {req0_ack, req1_ack}, 2'b10);
        req0_valid = 1'b0;
        wait_for("tie_done0", 2, 40, k);
        check("tie_result0", result, 32'd1 + y0);
        wait_for("tie_ack1", 1, 10, k);
        check("tie_second_latency", k, 2);
        req1_valid = 1'b0;
        wait_for("tie_done1", 3, 40, k);
        check("tie_result1", result, 32'd2 + y1);
        wait_for("tie_idle", 4, 5, k);

        // Both held valid: grants alternate, one idle cycle between operations.
        for (int r = 0; r < 2; r++) begin
            xc[r] = $urandom; yc[r] = $urandom;
        end
        req0_x = xc[0]; req0_y = yc[0]; req1_x = xc[1]; req1_y = yc[1];
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (!(req0_ack || req1_ack)) wait_for("rr_ack", 5, 10, k);
            w = req1_ack ? 1 : 0;
            check($sformatf("rr_grant_%0d", i), w, i % 2);
            exp_sum = xc[w] + yc[w];
            xc[w] = $urandom; yc[w] = $urandom;
            if (w == 1) begin req1_x = xc[1]; req1_y = yc[1]; end
            else begin req0_x = xc[0]; req0_y = yc[0]; end
            wait_for("rr_done", w == 1 ? 3 : 2, 40, k);
            check($sformatf("rr_result_%0d", i), result, exp_sum);
            low = 0;
            tick();
            while (!busy && low < 10) begin
                low++;
                tick();
            end
            check($sformatf("rr_busy_gap_%0d", i), low, 1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_for("rr_drain", 4, 40, k);

        // Reset while BUSY abandons the operation.
        req1_x = $urandom; req1_y = $urandom; req1_valid = 1'b1;
        wait_for("rst_ack", 1, 5, k);
        req1_valid = 1'b0;
        repeat (3) tick();
        check("rst_in_busy", busy, 1);
        pulse_reset();
        check("rst_busy_low", busy, 0);
        dones = 0;
        repeat (15) begin
            dones += int'(req0_done) + int'(req1_done);
            tick();
        end
        check("rst_no_done", dones, 0);
        check("rst_result_cleared", result, 0);
        req1_x = 32'd100; req1_y = 32'd23; req1_valid = 1'b1;
        wait_for("rst_fresh_ack", 1, 5, k);
        check("rst_fresh_ack_latency", k, 1);
        req1_valid = 1'b0;
        wait_for("rst_fresh_done", 3, 40, k);
        check("rst_fresh_result", result, 123);
        wait_for("rst_fresh_idle", 4, 5, k);

        // Spurious mm_done in IDLE, then in ISSUE.
        keep = result;
        tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        check("spur_idle_result", result, keep);
        check("spur_idle_ctrl", {busy, req0_done, req1_done}, 0);
        req0_x = 32'd40; req0_y = 32'd2; req0_valid = 1'b1;
        wait_for("spur_ack", 0, 5, k);
        req0_valid = 1'b0;
        spur = 1'b1;
        tick();
        spur = 1'b0;
        check("spur_issue_result", result, keep);
        wait_for("spur_done", 2, 40, k);
        check("spur_issue_latency", k, 10);
        check("spur_issue_final", result, 42);
        wait_for("spur_idle2", 4, 5, k);

        // Random traffic with occasional spurious completions outside BUSY.
        vr[0] = 1'b0; vr[1] = 1'b0;
        for (int c = 0; c < 500; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (vr[r] && sig(r)) begin
                    vr[r] = 1'b0;
                end else if (!vr[r] && $urandom_range(0, 3) == 0) begin
                    vr[r] = 1'b1;
                    xc[r] = $urandom;
                    yc[r] = $urandom;
                end
            end
            req0_valid = vr[0]; req0_x = xc[0]; req0_y = yc[0];
            req1_valid = vr[1]; req1_x = xc[1]; req1_y = yc[1];
            spur = (!busy || mm_start || req0_done || req1_done) && ($urandom_range(0, 15) == 0);
            tick();
        end
        spur = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        // A grant may have been decided on the last edge; let it finish.
        repeat (2) tick();
        if (busy) wait_for("final_drain", 4, 40, k);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
